mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sole owner of the CPU's byte-wide external memory bus (mem_a / mem_dout / mem_din / mem_wr). It arbitrates between the instruction-fetch requester (32-bit instruction reads) and the MEM-stage requester (1/2/4-byte loads and stores). Each granted access is sequenced as byte-serial transfers that honour the 2-cycle read / 1-cycle write memory protocol. Sits between stage_if / stage_mem and the cpu top-level memory ports; supersedes the bus-muxing portion of ctrl.

## Interface
- Parameters: none; widths come from shared defines (`InstAddrBus` = 32, `RegBus` = 32).
- clk_in  in  1  system clock; single clock domain.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  low = pause: all state frozen.
- if_req_i  in  1  IF read request; level, held until if_done_o.
- if_addr_i  in  32  IF byte address.
- if_done_o  out  1  one-cycle pulse; if_rdata_o valid this cycle.
- if_rdata_o  out  32  fetched instruction, little-endian.
- mem_req_i  in  1  MEM request; level, held until mem_done_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word.
- mem_addr_i  in  32  MEM byte address.
- mem_wdata_i  in  32  store data; byte k = [8k+7:8k].
- mem_done_o  out  1  one-cycle pulse; mem_rdata_o valid for loads.
- mem_rdata_o  out  32  raw load bytes, zero-extended; sign extension is done by stage_mem.
- mem_din  in  8  memory read data.
- mem_dout  out  8  memory write data.
- mem_a  out  32  memory address.
- mem_wr  out  1  1 = write.
- busy_o  out  1  high whenever state ≠ IDLE; feeds ctrl stall.

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR.
- Transfer length n: 4 for IF; 1/2/4 for MEM per mem_size_i.
- Arbitration happens only in IDLE, and only in cycles where neither done pulse is high.
  - mem_req_i wins over if_req_i (fixed priority).
  - Request inputs are latched at grant, so later changes are ignored, except for the IF abort below.
- Reads use an issue counter and a collect counter.
  - Byte k address = base + k, driven one byte per cycle.
  - mem_din for byte k is captured into lane k one cycle after its address was driven.
  - After the last collect, the FSM returns to IDLE and pulses the done output.
- Writes: each cycle drives mem_a = base + k, mem_dout = byte k, mem_wr = 1. After byte n-1, the FSM returns to IDLE and pulses done.
- IF abort: if if_req_i drops while in IF_RD, the FSM goes to IDLE next cycle with no if_done_o. This covers a branch flush.
- MEM transfers are never aborted.
- Unused lanes of mem_rdata_o read as 0.
- Pause (rdy_in = 0):
  - Counters, FSM and outputs are held; mem_wr is forced to 0.
  - The first cycle after rdy_in returns is a replay cycle: it re-issues the address at the collect pointer and captures nothing, so the in-flight read byte is re-fetched.
  - Writes resume at the current byte.
- Addresses with bits [17:16] = 2'b11 are I/O. They are handled identically; ordering of bytes ascending is guaranteed.
- Address arithmetic is 32-bit wrapping; no alignment check.

## Timing
- All outputs are registered.
- Reset values: mem_a = 0, mem_dout = 0, mem_wr = 0, if_done_o = 0, mem_done_o = 0, if_rdata_o = 0, mem_rdata_o = 0, busy_o = 0, state = IDLE.
- Let T be the cycle in which the grant is sampled.
- Read of n bytes:
  - mem_a = base + k in cycle T+1+k.
  - Byte k is captured at the end of cycle T+2+k.
  - Done pulses in cycle T+n+2: byte → T+3, half → T+4, word → T+6.
- Write of n bytes: mem_wr high in cycles T+1 … T+n; done pulses in T+n+1.
- The done cycle is a dead cycle for arbitration, so the next grant is sampled at T_done+1 at the earliest. This prevents double grants from a requester whose req is still high.
- Simultaneous IF and MEM requests in IDLE: MEM is granted; IF waits and is granted on the first eligible cycle after mem_done_o.
- Reset mid-transfer: IDLE on the next cycle, no done pulse, mem_wr = 0.

## Structure
- Shared defines header holds:
  - state encodings `ArbIdle`, `ArbIfRd`, `ArbMemRd`, `ArbMemWr`;
  - size codes `MemByte`, `MemHalf`, `MemWord`;
  - the I/O address-decode constant.
- Single module, no sub-module. The byte-lane capture/select logic is small enough to stay inline.
- Expected size: ~200 lines.

## Test plan
- IF word read at 0x1000, memory holds bytes 13 05 00 00:
  - mem_a = 0x1000…0x1003 in T+1…T+4;
  - if_done_o pulses at T+6 with if_rdata_o = 0x00000513.
- MEM half store of 0xBEEF to 0x2002:
  - mem_wr high T+1…T+2 with mem_a / mem_dout = 0x2002/EF, then 0x2003/BE;
  - mem_done_o at T+3.
- IF and MEM (byte load from 0x30000) raised in the same cycle:
  - MEM is served first, mem_done_o at T+3;
  - no grant sampled at T+3; IF grant sampled at T+4, with if_done_o 6 cycles later.
- IF read aborted by dropping if_req_i after 2 bytes:
  - FSM returns to IDLE next cycle with no if_done_o;
  - a subsequent MEM request is granted normally.
- rdy_in low for 3 cycles during a MEM word load:
  - mem_wr stays 0 and outputs are held;
  - on resume, the byte at the collect pointer is re-fetched;
  - final mem_rdata_o matches memory, with done delayed by pause length + 1.
- rst_in asserted mid-word-store: next cycle mem_wr = 0, busy_o = 0, no mem_done_o, and the remaining bytes are not written.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the byte-serial memory bus arbiter: bus widths,
// FSM state encodings and MEM access size codes.
package mem_arbiter_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned RegBus      = 32;

   typedef enum logic [1:0] {
      ArbIdle  = 2'd0,
      ArbIfRd  = 2'd1,
      ArbMemRd = 2'd2,
      ArbMemWr = 2'd3
   } arb_state_e;

   localparam logic [1:0] MemByte = 2'd0;
   localparam logic [1:0] MemHalf = 2'd1;
   localparam logic [1:0] MemWord = 2'd2;

   // Byte count of a transfer; the illegal size code 3 is treated as a word.
   function automatic logic [2:0] xfer_len(input logic [1:0] size);
      case (size)
         MemByte: return 3'd1;
         MemHalf: return 3'd2;
         MemWord: return 3'd4;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Owns the byte-wide external memory bus: arbitrates IF fetches against MEM
// loads/stores and sequences each grant as byte-serial reads or writes.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   if_req_i,
   input  logic [InstAddrBus-1:0] if_addr_i,
   output logic                   if_done_o,
   output logic [RegBus-1:0]      if_rdata_o,
   input  logic                   mem_req_i,
   input  logic                   mem_we_i,
   input  logic [1:0]             mem_size_i,
   input  logic [InstAddrBus-1:0] mem_addr_i,
   input  logic [RegBus-1:0]      mem_wdata_i,
   output logic                   mem_done_o,
   output logic [RegBus-1:0]      mem_rdata_o,
   input  logic [7:0]             mem_din,
   output logic [7:0]             mem_dout,
   output logic [InstAddrBus-1:0] mem_a,
   output logic                   mem_wr,
   output logic                   busy_o
);

   arb_state_e state, state_nxt;

   logic [InstAddrBus-1:0] base;
   logic [2:0]             len;
   logic [3:0][7:0]        wdata;
   logic [3:0][7:0]        lanes;
   logic [3:0][7:0]        merged;
   logic [2:0]             issue;
   logic [2:0]             collect;
   logic [1:0]             a_tag, d_tag;
   logic                   a_live, d_live;
   logic                   replay;

   logic grant_if, grant_mem, issue_en, reissue, cap, fin_rd, fin_wr, abort;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state  <= ArbIdle;
         busy_o <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_o <= (state_nxt != ArbIdle);
      end
   end

   // Reads are tagged with the byte index on the bus, and a returning byte is
   // captured only when its tag matches the collect pointer, so a pause or a
   // replay can never land a byte in the wrong lane.
   always_comb begin
      state_nxt = state;
      grant_if  = 1'b0;
      grant_mem = 1'b0;
      issue_en  = 1'b0;
      reissue   = 1'b0;
      cap       = 1'b0;
      fin_rd    = 1'b0;
      fin_wr    = 1'b0;
      abort     = 1'b0;
      merged    = lanes;
      merged[collect[1:0]] = mem_din;
      if (rdy_in) begin
         case (state)
            ArbIdle: begin
               if (!if_done_o && !mem_done_o) begin
                  if (mem_req_i) begin
                     grant_mem = 1'b1;
                     state_nxt = mem_we_i ? ArbMemWr : ArbMemRd;
                  end else if (if_req_i) begin
                     grant_if  = 1'b1;
                     state_nxt = ArbIfRd;
                  end
               end
            end
            ArbIfRd, ArbMemRd: begin
               if (state == ArbIfRd && !if_req_i) begin
                  abort     = 1'b1;
                  state_nxt = ArbIdle;
               end else if (replay) begin
                  reissue = 1'b1;
               end else begin
                  issue_en = (issue < len);
                  cap      = d_live && (d_tag == collect[1:0]);
                  if (cap && collect == len - 3'd1) begin
                     fin_rd    = 1'b1;
                     state_nxt = ArbIdle;
                  end
               end
            end
            ArbMemWr: begin
               if (issue < len) begin
                  issue_en = 1'b1;
               end else begin
                  fin_wr    = 1'b1;
                  state_nxt = ArbIdle;
               end
            end
            default: state_nxt = ArbIdle;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_a       <= '0;
         mem_dout    <= '0;
         mem_wr      <= 1'b0;
         if_done_o   <= 1'b0;
         mem_done_o  <= 1'b0;
         if_rdata_o  <= '0;
         mem_rdata_o <= '0;
         base        <= '0;
         len         <= '0;
         wdata       <= '0;
         lanes       <= '0;
         issue       <= '0;
         collect     <= '0;
         a_tag       <= '0;
         a_live      <= 1'b0;
         d_tag       <= '0;
         d_live      <= 1'b0;
         replay      <= 1'b0;
      end else begin
         replay <= !rdy_in;
         if (!rdy_in) begin
            mem_wr <= 1'b0;
         end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            d_tag      <= a_tag;
            d_live     <= a_live;
            if (grant_if || grant_mem) begin
               base    <= grant_mem ? mem_addr_i : if_addr_i;
               len     <= grant_mem ? xfer_len(mem_size_i) : 3'd4;
               wdata   <= mem_wdata_i;
               lanes   <= '0;
               issue   <= 3'd1;
               collect <= '0;
               mem_a   <= grant_mem ? mem_addr_i : if_addr_i;
               a_tag   <= '0;
               a_live  <= !(grant_mem && mem_we_i);
               mem_wr  <= grant_mem && mem_we_i;
               if (grant_mem && mem_we_i) mem_dout <= mem_wdata_i[7:0];
            end
            if (reissue) begin
               mem_a <= base + 32'(collect);
               a_tag <= collect[1:0];
               issue <= collect + 3'd1;
            end
            if (issue_en) begin
               mem_a <= base + 32'(issue);
               a_tag <= issue[1:0];
               issue <= issue + 3'd1;
               if (state == ArbMemWr) begin
                  mem_dout <= wdata[issue[1:0]];
                  mem_wr   <= 1'b1;
               end
            end
            if (cap) begin
               lanes[collect[1:0]] <= mem_din;
               collect             <= collect + 3'd1;
            end
            if (fin_rd) begin
               a_live <= 1'b0;
               if (state == ArbIfRd) begin
                  if_rdata_o <= merged;
                  if_done_o  <= 1'b1;
               end else begin
                  mem_rdata_o <= merged;
                  mem_done_o  <= 1'b1;
               end
            end
            if (abort) a_live <= 1'b0;
            if (fin_wr) begin
               mem_wr     <= 1'b0;
               mem_done_o <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 2-cycle-read byte memory.
module tb_mem_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic        if_req_i, if_done_o;
   logic [31:0] if_addr_i, if_rdata_o;
   logic        mem_req_i, mem_we_i, mem_done_o;
   logic [1:0]  mem_size_i;
   logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, busy_o;

   int checks = 0;
   int errors = 0;
   int wr_count = 0;
   logic [7:0] ram [logic [31:0]];

   always #5 clk_in = ~clk_in;

   mem_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_rdata_o(if_rdata_o),
      .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
      .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_done_o(mem_done_o),
      .mem_rdata_o(mem_rdata_o), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .busy_o(busy_o)
   );

   // Memory: data for the address seen in cycle c appears on mem_din in c+1.
   always @(posedge clk_in) begin
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
      if (mem_wr) begin
         ram[mem_a] = mem_dout;
         wr_count++;
      end
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      step();
      step();
      rst_in = 1'b0;
      checks++;
      if ({mem_a, mem_dout, mem_wr, if_done_o, mem_done_o, if_rdata_o, mem_rdata_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: mem_a=%h dout=%h wr=%b ifd=%b memd=%b ifr=%h memr=%h required all zero",
                  mem_a, mem_dout, mem_wr, if_done_o, mem_done_o, if_rdata_o, mem_rdata_o);
      end
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy_o); end
   endtask

   task automatic test_if_read();
      if_addr_i = 32'h1000;
      if_req_i  = 1'b1;                     // cycle T
      for (int k = 0; k < 4; k++) begin
         step();                            // T+1+k
         checks++;
         if (mem_a !== 32'h1000 + k) begin
            errors++; $display("FAIL if_addr_%0d: got %h required %h", k, mem_a, 32'h1000 + k);
         end
      end
      step();                               // T+5
      checks++;
      if (if_done_o !== 1'b0) begin errors++; $display("FAIL if_done_early: got %b required 0", if_done_o); end
      step();                               // T+6
      checks++;
      if (if_done_o !== 1'b1) begin errors++; $display("FAIL if_done: got %b required 1", if_done_o); end
      checks++;
      if (if_rdata_o !== 32'h00000513) begin
         errors++; $display("FAIL if_rdata: got %h required 00000513", if_rdata_o);
      end
      if_req_i = 1'b0;
      step();
   endtask

   task automatic test_half_store();
      mem_addr_i  = 32'h2002;
      mem_wdata_i = 32'h0000BEEF;
      mem_size_i  = 2'd1;
      mem_we_i    = 1'b1;
      mem_req_i   = 1'b1;                   // T
      step();                               // T+1
      checks++;
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2002, 8'hEF}) begin
         errors++; $display("FAIL store_b0: got wr=%b a=%h d=%h required 1/00002002/ef", mem_wr, mem_a, mem_dout);
      end
      step();                               // T+2
      checks++;
      if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2003, 8'hBE}) begin
         errors++; $display("FAIL store_b1: got wr=%b a=%h d=%h required 1/00002003/be", mem_wr, mem_a, mem_dout);
      end
      step();                               // T+3
      checks++;
      if ({mem_done_o, mem_wr} !== 2'b10) begin
         errors++; $display("FAIL store_done: got done=%b wr=%b required 1/0", mem_done_o, mem_wr);
      end
      mem_req_i = 1'b0;
      mem_we_i  = 1'b0;
      step();
      checks++;
      if ({ram[32'h2002], ram[32'h2003]} !== 16'hEFBE) begin
         errors++; $display("FAIL store_ram: got %h%h required efbe", ram[32'h2002], ram[32'h2003]);
      end
   endtask

   task automatic test_priority();
      ram[32'h30000] = 8'hA5;
      if_addr_i  = 32'h1000;
      mem_addr_i = 32'h30000;
      mem_size_i = 2'd0;
      mem_we_i   = 1'b0;
      if_req_i   = 1'b1;
      mem_req_i  = 1'b1;                    // T
      step();                               // T+1
      checks++;
      if (mem_a !== 32'h30000) begin errors++; $display("FAIL prio_first_addr: got %h required 00030000", mem_a); end
      step();
      step();                               // T+3
      checks++;
      if ({mem_done_o, if_done_o, busy_o} !== 3'b100) begin
         errors++; $display("FAIL prio_mem_done: got memd=%b ifd=%b busy=%b required 1/0/0", mem_done_o, if_done_o, busy_o);
      end
      checks++;
      if (mem_rdata_o !== 32'h000000A5) begin errors++; $display("FAIL prio_mem_rdata: got %h required 000000a5", mem_rdata_o); end
      mem_req_i = 1'b0;
      step();                               // T+4: IF grant sampled
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL prio_dead_cycle: busy got %b required 0", busy_o); end
      step();                               // T+5
      checks++;
      if ({busy_o, mem_a} !== {1'b1, 32'h1000}) begin
         errors++; $display("FAIL prio_if_start: got busy=%b a=%h required 1/00001000", busy_o, mem_a);
      end
      for (int i = 0; i < 4; i++) step();   // T+9
      checks++;
      if (if_done_o !== 1'b0) begin errors++; $display("FAIL prio_if_early: got %b required 0", if_done_o); end
      step();                               // T+10
      checks++;
      if ({if_done_o, if_rdata_o} !== {1'b1, 32'h00000513}) begin
         errors++; $display("FAIL prio_if_done: got done=%b data=%h required 1/00000513", if_done_o, if_rdata_o);
      end
      if_req_i = 1'b0;
      step();
   endtask

   task automatic test_if_abort();
      logic seen = 1'b0;
      if_addr_i = 32'h1000;
      if_req_i  = 1'b1;                     // T
      for (int i = 0; i < 4; i++) step();   // T+4, bytes 0 and 1 captured
      if_req_i = 1'b0;
      step();                               // T+5
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL abort_idle: busy got %b required 0", busy_o); end
      for (int i = 0; i < 4; i++) begin
         if (if_done_o) seen = 1'b1;
         step();
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got if_done seen=%b required 0", seen); end
      mem_addr_i = 32'h1001;
      mem_size_i = 2'd0;
      mem_we_i   = 1'b0;
      mem_req_i  = 1'b1;                    // T'
      step();
      step();
      step();                               // T'+3
      checks++;
      if ({mem_done_o, mem_rdata_o} !== {1'b1, 32'h00000005}) begin
         errors++; $display("FAIL abort_then_mem: got done=%b data=%h required 1/00000005", mem_done_o, mem_rdata_o);
      end
      mem_req_i = 1'b0;
      step();
   endtask

   task automatic test_pause();
      ram[32'h4000] = 8'h11; ram[32'h4001] = 8'h22;
      ram[32'h4002] = 8'h33; ram[32'h4003] = 8'h44;
      mem_addr_i = 32'h4000;
      mem_size_i = 2'd2;
      mem_we_i   = 1'b0;
      mem_req_i  = 1'b1;                    // T
      for (int i = 0; i < 5; i++) step();   // T+5
      rdy_in = 1'b0;                        // paused T+5..T+7
      step();                               // T+6
      checks++;
      if ({mem_wr, busy_o, mem_done_o, mem_a} !== {1'b0, 1'b1, 1'b0, 32'h4003}) begin
         errors++; $display("FAIL pause_hold: got wr=%b busy=%b done=%b a=%h required 0/1/0/00004003",
                            mem_wr, busy_o, mem_done_o, mem_a);
      end
      step();                               // T+7
      checks++;
      if ({mem_wr, mem_a} !== {1'b0, 32'h4003}) begin
         errors++; $display("FAIL pause_hold2: got wr=%b a=%h required 0/00004003", mem_wr, mem_a);
      end
      step();                               // T+8 replay
      rdy_in = 1'b1;
      step();                               // T+9
      checks++;
      if (mem_done_o !== 1'b0) begin errors++; $display("FAIL pause_done_early: got %b required 0", mem_done_o); end
      step();                               // T+10
      checks++;
      if ({mem_done_o, mem_rdata_o} !== {1'b1, 32'h44332211}) begin
         errors++; $display("FAIL pause_done: got done=%b data=%h required 1/44332211", mem_done_o, mem_rdata_o);
      end
      mem_req_i = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_store();
      int base_writes;
      logic seen = 1'b0;
      ram[32'h5002] = 8'h77; ram[32'h5003] = 8'h88;
      base_writes = wr_count;
      mem_addr_i  = 32'h5000;
      mem_wdata_i = 32'hCAFEF00D;
      mem_size_i  = 2'd2;
      mem_we_i    = 1'b1;
      mem_req_i   = 1'b1;                   // T
      step();
      step();                               // T+2
      rst_in    = 1'b1;
      mem_req_i = 1'b0;
      mem_we_i  = 1'b0;
      step();                               // T+3
      rst_in = 1'b0;
      checks++;
      if ({mem_wr, busy_o, mem_done_o} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_store: got wr=%b busy=%b done=%b required 0/0/0", mem_wr, busy_o, mem_done_o);
      end
      for (int i = 0; i < 5; i++) begin
         if (mem_done_o || mem_wr) seen = 1'b1;
         step();
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_activity: got seen=%b required 0", seen); end
      checks++;
      if (wr_count - base_writes !== 2) begin
         errors++; $display("FAIL rst_write_count: got %0d required 2", wr_count - base_writes);
      end
      checks++;
      if ({ram[32'h5000], ram[32'h5001], ram[32'h5002], ram[32'h5003]} !== 32'h0DF07788) begin
         errors++; $display("FAIL rst_ram: got %h%h%h%h required 0df07788",
                            ram[32'h5000], ram[32'h5001], ram[32'h5002], ram[32'h5003]);
      end
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1;
      if_req_i = 1'b0; if_addr_i = '0;
      mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0;
      mem_addr_i = '0; mem_wdata_i = '0;
      ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
      ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
      test_reset();
      test_if_read();
      test_half_store();
      test_priority();
      test_if_abort();
      test_pause();
      test_reset_mid_store();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
